// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control unit: state encodings,
// opcodes, ALUOp codes and the ALUControl encoding driven to the ALU.
package ctrl_pkg;

    localparam int unsigned CTRL_STATE_W = 4;

    typedef enum logic [CTRL_STATE_W-1:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        BEQ,
        JAL
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps ALUOp/funct3/op[5]/funct7b5 to the 3-bit ALUControl.
// Ports: alu_op, funct3, op5, funct7b5 in; alu_control_c, bad_funct_c out
// (bad_funct_c flags an unsupported funct3 while ALUOp selects funct decode).
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control_c,
    output logic       bad_funct_c
);

    always_comb begin
        alu_control_c = ALU_ADD;
        bad_funct_c   = 1'b0;
        case (alu_op)
            ALUOP_ADD: alu_control_c = ALU_ADD;
            ALUOP_SUB: alu_control_c = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op[5]=1) uses funct7b5 to pick sub.
                    3'b000:  alu_control_c = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_c = ALU_SLT;
                    3'b110:  alu_control_c = ALU_OR;
                    3'b111:  alu_control_c = ALU_AND;
                    default: bad_funct_c   = 1'b1;
                endcase
            end
            default: alu_control_c = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM control unit for the multicycle RV32I core.
// Inputs: clk, reset (async, active-high), op, funct3, funct7b5, zero.
// Outputs: PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
// ALUSrcB, ImmSrc, ALUControl, illegal (one-cycle pulse).
// Optional: CTRL_BNE_EN makes the branch state also handle bne (funct3=001).
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int unsigned STATE_W = CTRL_STATE_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal
);

    logic [STATE_W-1:0] state_q;
    state_e             state_cur;
    state_e             state_d;

    logic       pc_update_c;
    logic       branch_c;
    logic       mem_write_c;
    logic       ir_write_c;
    logic       reg_write_c;
    logic       exec_c;
    logic       decode_bad_c;
    logic [1:0] alu_op_c;
    logic       bad_funct_c;
    logic       take_branch_c;
    logic       branch_bad_c;

    assign state_cur = state_e'(state_q);

    // State register; reset lands in FETCH immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= STATE_W'(FETCH);
        end else begin
            state_q <= STATE_W'(state_d);
        end
    end

    // Next state and Moore outputs.
    always_comb begin
        state_d      = FETCH;
        pc_update_c  = 1'b0;
        branch_c     = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        exec_c       = 1'b0;
        decode_bad_c = 1'b0;
        alu_op_c     = ALUOP_ADD;
        AdrSrc       = 1'b0;
        ResultSrc    = 2'b00;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        case (state_cur)
            FETCH: begin
                state_d     = DECODE;
                ir_write_c  = 1'b1;
                pc_update_c = 1'b1;
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTER;
                    OP_I:         state_d = EXECUTEI;
                    OP_JAL:       state_d = JAL;
                    OP_BEQ:       state_d = BEQ;
                    default:      decode_bad_c = 1'b1;
                endcase
            end
            MEMADR: begin
                state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD: begin
                state_d = MEMWB;
                AdrSrc  = 1'b1;
            end
            MEMWB: begin
                ResultSrc   = 2'b01;
                reg_write_c = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_c = 1'b1;
            end
            EXECUTER: begin
                state_d  = ALUWB;
                exec_c   = 1'b1;
                ALUSrcA  = 2'b10;
                alu_op_c = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                state_d  = ALUWB;
                exec_c   = 1'b1;
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                alu_op_c = ALUOP_FUNCT;
            end
            ALUWB: begin
                reg_write_c = 1'b1;
            end
            BEQ: begin
                branch_c = 1'b1;
                ALUSrcA  = 2'b10;
                alu_op_c = ALUOP_SUB;
            end
            JAL: begin
                state_d     = ALUWB;
                pc_update_c = 1'b1;
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
            end
            default: state_d = FETCH;
        endcase
    end

    // Branch condition; zero reflects rs1 - rs2 computed in the branch state.
`ifdef CTRL_BNE_EN
    assign branch_bad_c  = (funct3[2:1] != 2'b00);
    assign take_branch_c = ~branch_bad_c & (zero ^ funct3[0]);
`else
    assign branch_bad_c  = (funct3 != 3'b000);
    assign take_branch_c = ~branch_bad_c & zero;
`endif

    // Immediate format follows the opcode alone.
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op        (alu_op_c),
        .funct3        (funct3),
        .op5           (op[5]),
        .funct7b5      (funct7b5),
        .alu_control_c (ALUControl),
        .bad_funct_c   (bad_funct_c)
    );

    // Write enables and illegal are suppressed while reset is held.
    assign PCWrite  = ~reset & (pc_update_c | (branch_c & take_branch_c));
    assign MemWrite = ~reset & mem_write_c;
    assign IRWrite  = ~reset & ir_write_c;
    assign RegWrite = ~reset & reg_write_c;
    assign illegal  = ~reset & (decode_bad_c | (exec_c & bad_funct_c) |
                                (branch_c & branch_bad_c));

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: a table of instructions is walked through
// the FSM; a reference model pushes the expected per-cycle outputs into a
// scoreboard queue that is popped and compared every cycle.
module tb_multicycle_controller;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam int S_F   = 0;
    localparam int S_D   = 1;
    localparam int S_MA  = 2;
    localparam int S_MR  = 3;
    localparam int S_MWB = 4;
    localparam int S_MW  = 5;
    localparam int S_ER  = 6;
    localparam int S_EI  = 7;
    localparam int S_AWB = 8;
    localparam int S_B   = 9;
    localparam int S_J   = 10;

    localparam int NVEC = 18;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] imm;
        logic [2:0] alu;
        logic       ill;
    } ctrl_t;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       zero;
    } vec_t;

    typedef struct {
        string name;
        ctrl_t v;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       illegal;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    vec_t vecs[NVEC];

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .illegal    (illegal)
    );

    // Reference outputs for one state of the walk of instruction v.
    function automatic ctrl_t model(int s, vec_t v);
        ctrl_t c;
        c = '0;
        if (v.op == OP_SW)       c.imm = 2'b01;
        else if (v.op == OP_BEQ) c.imm = 2'b10;
        else if (v.op == OP_JAL) c.imm = 2'b11;
        case (s)
            S_F:   begin c.pcw = 1'b1; c.irw = 1'b1; c.rs = 2'b10; c.sb = 2'b10; end
            S_D: begin
                c.sa  = 2'b01;
                c.sb  = 2'b01;
                c.ill = !(v.op inside {OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ});
            end
            S_MA:  begin c.sa = 2'b10; c.sb = 2'b01; end
            S_MR:  c.adr = 1'b1;
            S_MWB: begin c.rs = 2'b01; c.rw = 1'b1; end
            S_MW:  begin c.adr = 1'b1; c.mw = 1'b1; end
            S_ER, S_EI: begin
                c.sa = 2'b10;
                c.sb = (s == S_EI) ? 2'b01 : 2'b00;
                case (v.f3)
                    3'b000:  c.alu = (v.op[5] && v.f7) ? 3'b001 : 3'b000;
                    3'b010:  c.alu = 3'b101;
                    3'b110:  c.alu = 3'b011;
                    3'b111:  c.alu = 3'b010;
                    default: c.ill = 1'b1;
                endcase
            end
            S_AWB: c.rw = 1'b1;
            S_B: begin
                c.sa  = 2'b10;
                c.alu = 3'b001;
`ifdef CTRL_BNE_EN
                if (v.f3 == 3'b000)      c.pcw = v.zero;
                else if (v.f3 == 3'b001) c.pcw = !v.zero;
                else                     c.ill = 1'b1;
`else
                if (v.f3 == 3'b000) c.pcw = v.zero;
                else                c.ill = 1'b1;
`endif
            end
            S_J: begin c.pcw = 1'b1; c.sa = 2'b01; c.sb = 2'b10; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic ctrl_t reset_exp(vec_t v);
        ctrl_t c;
        c = model(S_F, v);
        c.pcw = 1'b0;
        c.irw = 1'b0;
        c.mw  = 1'b0;
        c.rw  = 1'b0;
        c.ill = 1'b0;
        return c;
    endfunction

    // Push the expected output of every cycle of instruction v; returns its length.
    function automatic int push_instr(vec_t v);
        int p[$];
        p.push_back(S_F);
        p.push_back(S_D);
        case (v.op)
            OP_LW:  begin p.push_back(S_MA); p.push_back(S_MR); p.push_back(S_MWB); end
            OP_SW:  begin p.push_back(S_MA); p.push_back(S_MW); end
            OP_R:   begin p.push_back(S_ER); p.push_back(S_AWB); end
            OP_I:   begin p.push_back(S_EI); p.push_back(S_AWB); end
            OP_JAL: begin p.push_back(S_J);  p.push_back(S_AWB); end
            OP_BEQ: p.push_back(S_B);
            default: ;
        endcase
        foreach (p[i]) exp_q.push_back('{$sformatf("%s/c%0d", v.name, i + 1), model(p[i], v)});
        return p.size();
    endfunction

    task automatic check_cycle();
        exp_t  e;
        ctrl_t got;
        got = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal};
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: got %b, required a queued expectation", got);
            return;
        end
        e = exp_q.pop_front();
        if (got !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (pcw adr mw irw rw rs sa sb imm alu ill)",
                     e.name, got, e.v);
        end
        n_tests++;
        if (ALUControl inside {3'b100, 3'b110, 3'b111}) begin
            n_fail++;
            $display("FAIL %s alu_code: got %b required one of 000/001/010/011/101",
                     e.name, ALUControl);
        end
    endtask

    // Starts in FETCH just after a negedge; ends at the negedge of the next FETCH.
    task automatic run_instr(input vec_t v);
        int n;
        op       = v.op;
        funct3   = v.f3;
        funct7b5 = v.f7;
        zero     = v.zero;
        n = push_instr(v);
        for (int i = 0; i < n; i++) begin
            #1;
            check_cycle();
            @(negedge clk);
        end
    endtask

    initial begin
        vec_t sw_v;
        vec_t jal_v;

        vecs[0]  = '{"lw",       OP_LW,      3'b010, 1'b0, 1'b0};
        vecs[1]  = '{"sw",       OP_SW,      3'b010, 1'b0, 1'b1};
        vecs[2]  = '{"add",      OP_R,       3'b000, 1'b0, 1'b0};
        vecs[3]  = '{"sub",      OP_R,       3'b000, 1'b1, 1'b0};
        vecs[4]  = '{"addi_f7",  OP_I,       3'b000, 1'b1, 1'b0};
        vecs[5]  = '{"slt",      OP_R,       3'b010, 1'b0, 1'b0};
        vecs[6]  = '{"or",       OP_R,       3'b110, 1'b0, 1'b0};
        vecs[7]  = '{"and",      OP_R,       3'b111, 1'b0, 1'b0};
        vecs[8]  = '{"slti",     OP_I,       3'b010, 1'b0, 1'b0};
        vecs[9]  = '{"beq_t",    OP_BEQ,     3'b000, 1'b0, 1'b1};
        vecs[10] = '{"beq_nt",   OP_BEQ,     3'b000, 1'b0, 1'b0};
        vecs[11] = '{"bne_z0",   OP_BEQ,     3'b001, 1'b0, 1'b0};
        vecs[12] = '{"bne_z1",   OP_BEQ,     3'b001, 1'b0, 1'b1};
        vecs[13] = '{"blt",      OP_BEQ,     3'b100, 1'b0, 1'b1};
        vecs[14] = '{"jal",      OP_JAL,     3'b000, 1'b1, 1'b0};
        vecs[15] = '{"ill_op0",  7'b0000000, 3'b000, 1'b0, 1'b0};
        vecs[16] = '{"sll_bad",  OP_R,       3'b001, 1'b0, 1'b0};
        vecs[17] = '{"ill_op7f", 7'b1111111, 3'b111, 1'b1, 1'b1};

        reset    = 1'b1;
        op       = 7'b0000000;
        funct3   = 3'b000;
        funct7b5 = 1'b0;
        zero     = 1'b0;

        // Held reset: FETCH mux values, every enable low.
        repeat (2) @(negedge clk);
        exp_q.push_back('{"reset_hold", reset_exp(vecs[15])});
        #1;
        check_cycle();
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_instr(vecs[i]);
        end

        // Reset asserted mid-MEMWRITE abandons the store at once.
        sw_v     = vecs[1];
        op       = sw_v.op;
        funct3   = sw_v.f3;
        funct7b5 = sw_v.f7;
        zero     = sw_v.zero;
        void'(push_instr(sw_v));
        for (int i = 0; i < 4; i++) begin
            #1;
            check_cycle();
            if (i < 3) @(negedge clk);
        end
        #2;
        reset = 1'b1;
        exp_q.push_back('{"reset_mid_mw", reset_exp(sw_v)});
        #1;
        check_cycle();
        @(negedge clk);
        exp_q.push_back('{"reset_held_mw", reset_exp(sw_v)});
        #1;
        check_cycle();
        reset = 1'b0;

        // First cycle after release is FETCH; then a full jal follows.
        jal_v = vecs[14];
        run_instr(jal_v);

        // Back-to-back lw then closing FETCH check.
        run_instr(vecs[0]);
        exp_q.push_back('{"final_fetch", model(S_F, vecs[0])});
        #1;
        check_cycle();

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
